sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter_if.sv | 20 ++
 rtl/sprite_blitter.sv | 219 +++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Avalon-MM slave bundle for sprite_blitter: register writes, status reads
// and the write-stall handshake.
interface sprite_blitter_if;
  logic [2:0]  slave_address;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;

  modport master (
    output slave_address, slave_write, slave_writedata, slave_read,
    input  slave_readdata, slave_waitrequest
  );

  modport slave (
    input  slave_address, slave_write, slave_writedata, slave_read,
    output slave_readdata, slave_waitrequest
  );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter / rectangle filler into a double-buffered framebuffer with vsync-timed swap.
// Optional macro SPRITE_BLITTER_TRANSPARENCY_EN: all-zero blit texels are not written.
module sprite_blitter #(
  parameter int FB_W    = 320,
  parameter int FB_H    = 240,
  parameter int PIX_W   = 6,
  parameter int TEX_AW  = 14,
  parameter int COORD_W = 11,
  parameter int FB_AW   = 18
) (
  input  logic               clk,
  input  logic               reset,
  sprite_blitter_if.slave    bus,
  output logic [TEX_AW-1:0]  tex_addr,
  input  logic [PIX_W-1:0]   tex_q,
  output logic               fb_we,
  output logic [FB_AW-1:0]   fb_addr,
  output logic [PIX_W-1:0]   fb_wdata,
  input  logic               vsync,
  output logic               display_buf
);
  localparam int FB_MAX  = (FB_W > FB_H) ? FB_W : FB_H;
  localparam int DIM_MAX = (FB_MAX > 128) ? FB_MAX : 128;
  localparam int CNT_W   = $clog2(DIM_MAX + 1);
  localparam int PW      = ((COORD_W > CNT_W) ? COORD_W : CNT_W) + 2;
  localparam logic signed [PW-1:0] FB_W_S = PW'(FB_W);
  localparam logic signed [PW-1:0] FB_H_S = PW'(FB_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                     state_q, state_d;
  logic signed [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic signed [COORD_W-1:0]  run_x_q, run_x_d, run_y_q, run_y_d;
  logic [TEX_AW-1:0]          tex_base_q, tex_base_d;
  logic [6:0]                 tex_w_q, tex_w_d, tex_h_q, tex_h_d;
  logic [PIX_W-1:0]           fill_q, fill_d;
  logic                       mode_q, mode_d;
  logic                       back_q, back_d;
  logic [CNT_W-1:0]           run_w_q, run_w_d, run_h_q, run_h_d;
  logic [CNT_W-1:0]           col_q, col_d, row_q, row_d;
  logic [TEX_AW-1:0]          tex_addr_q, tex_addr_d;
  logic                       fb_we_q, fb_we_d;
  logic [FB_AW-1:0]           fb_addr_q, fb_addr_d;
  logic                       display_buf_q, display_buf_d;
  logic                       swap_pending_q, swap_pending_d;
  logic [15:0]                frame_count_q, frame_count_d;

  logic                       busy, wr_ok, cmd_acc, swap_wr, swap_fire;
  logic                       last_col, last_elem, in_bounds;
  logic signed [PW-1:0]       px, py;
  logic                       unused_wdata;

  always_comb begin
    busy      = (state_q != S_IDLE);
    wr_ok     = bus.slave_write & ~busy;
    cmd_acc   = wr_ok & (bus.slave_address == 3'd5);
    swap_wr   = wr_ok & (bus.slave_address == 3'd7);
    // A swap may not coincide with a command start: the new command has already chosen its back buffer.
    swap_fire = vsync & swap_pending_q & ~busy & ~cmd_acc;

    px = $signed({{(PW-COORD_W){run_x_q[COORD_W-1]}}, run_x_q})
       + $signed({{(PW-CNT_W){1'b0}}, col_q});
    py = $signed({{(PW-COORD_W){run_y_q[COORD_W-1]}}, run_y_q})
       + $signed({{(PW-CNT_W){1'b0}}, row_q});
    in_bounds = ~px[PW-1] & (px < FB_W_S) & ~py[PW-1] & (py < FB_H_S);
    last_col  = (col_q == run_w_q - CNT_W'(1));
    last_elem = last_col & (row_q == run_h_q - CNT_W'(1));

    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    run_x_d    = run_x_q;
    run_y_d    = run_y_q;
    tex_base_d = tex_base_q;
    tex_w_d    = tex_w_q;
    tex_h_d    = tex_h_q;
    fill_d     = fill_q;
    mode_d     = mode_q;
    back_d     = back_q;
    run_w_d    = run_w_q;
    run_h_d    = run_h_q;
    col_d      = col_q;
    row_d      = row_q;
    tex_addr_d = tex_addr_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;

    if (wr_ok) begin
      case (bus.slave_address)
        3'd0: x_d        = bus.slave_writedata[COORD_W-1:0];
        3'd1: y_d        = bus.slave_writedata[COORD_W-1:0];
        3'd2: tex_base_d = bus.slave_writedata[TEX_AW-1:0];
        3'd3: begin
          tex_w_d = bus.slave_writedata[6:0];
          tex_h_d = bus.slave_writedata[14:8];
        end
        3'd4: fill_d     = bus.slave_writedata[PIX_W-1:0];
        3'd5: mode_d     = bus.slave_writedata[0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          back_d = ~display_buf_q;
          col_d  = '0;
          row_d  = '0;
          if (bus.slave_writedata[0]) begin
            // Fill reuses the scan engine over the whole screen with origin (0,0).
            run_x_d = '0;
            run_y_d = '0;
            run_w_d = CNT_W'(FB_W);
            run_h_d = CNT_W'(FB_H);
            state_d = S_RUN;
          end else begin
            run_x_d    = x_q;
            run_y_d    = y_q;
            run_w_d    = CNT_W'(tex_w_q);
            run_h_d    = CNT_W'(tex_h_q);
            tex_addr_d = tex_base_q;
            state_d    = ((tex_w_q == '0) || (tex_h_q == '0)) ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        fb_we_d   = in_bounds;
        fb_addr_d = (back_q ? FB_AW'(FB_W * FB_H) : '0)
                  + FB_AW'($unsigned(py)) * FB_AW'(FB_W)
                  + FB_AW'($unsigned(px));
        if (last_elem) begin
          state_d = S_DRAIN;
        end else begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + CNT_W'(1);
          end else begin
            col_d = col_q + CNT_W'(1);
          end
          if (!mode_q) tex_addr_d = tex_addr_q + TEX_AW'(1);
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    display_buf_d  = display_buf_q ^ swap_fire;
    swap_pending_d = swap_fire ? 1'b0 : (swap_pending_q | swap_wr);
    frame_count_d  = swap_fire ? frame_count_q + 16'd1 : frame_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      x_q            <= '0;
      y_q            <= '0;
      run_x_q        <= '0;
      run_y_q        <= '0;
      tex_base_q     <= '0;
      tex_w_q        <= '0;
      tex_h_q        <= '0;
      fill_q         <= '0;
      mode_q         <= 1'b0;
      back_q         <= 1'b0;
      run_w_q        <= '0;
      run_h_q        <= '0;
      col_q          <= '0;
      row_q          <= '0;
      tex_addr_q     <= '0;
      fb_we_q        <= 1'b0;
      fb_addr_q      <= '0;
      display_buf_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      run_x_q        <= run_x_d;
      run_y_q        <= run_y_d;
      tex_base_q     <= tex_base_d;
      tex_w_q        <= tex_w_d;
      tex_h_q        <= tex_h_d;
      fill_q         <= fill_d;
      mode_q         <= mode_d;
      back_q         <= back_d;
      run_w_q        <= run_w_d;
      run_h_q        <= run_h_d;
      col_q          <= col_d;
      row_q          <= row_d;
      tex_addr_q     <= tex_addr_d;
      fb_we_q        <= fb_we_d;
      fb_addr_q      <= fb_addr_d;
      display_buf_q  <= display_buf_d;
      swap_pending_q <= swap_pending_d;
      frame_count_q  <= frame_count_d;
    end
  end

  // Texel data arrives one cycle after its address, in step with the delayed write strobe.
  always_comb begin
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    fb_we = fb_we_q & (mode_q | (tex_q != '0));
`else
    fb_we = fb_we_q;
`endif
    fb_addr     = fb_addr_q;
    fb_wdata    = mode_q ? fill_q : tex_q;
    tex_addr    = tex_addr_q;
    display_buf = display_buf_q;

    bus.slave_waitrequest = bus.slave_write & busy;
    bus.slave_readdata    = '0;
    if (bus.slave_read && (bus.slave_address == 3'd6))
      bus.slave_readdata = {frame_count_q, 13'b0, swap_pending_q, display_buf_q, busy};

    unused_wdata = ^bus.slave_writedata;
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a reference model queues expected
// framebuffer writes, a monitor pops and compares them as the DUT emits them.
module tb_sprite_blitter;
  localparam int FB_W = 40, FB_H = 30, PIX_W = 6, TEX_AW = 14, COORD_W = 11, FB_AW = 12;
  localparam int NPIX  = FB_W * FB_H;
  localparam int TMASK = (1 << TEX_AW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [TEX_AW-1:0] tex_addr;
  logic [PIX_W-1:0]  tex_q = '0;
  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  logic [PIX_W-1:0]  fb_wdata;
  logic              vsync;
  logic              display_buf;

  sprite_blitter_if bus();

  sprite_blitter #(
    .FB_W(FB_W), .FB_H(FB_H), .PIX_W(PIX_W),
    .TEX_AW(TEX_AW), .COORD_W(COORD_W), .FB_AW(FB_AW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .tex_addr(tex_addr), .tex_q(tex_q),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .vsync(vsync), .display_buf(display_buf)
  );

  always #5 clk = ~clk;

  logic [PIX_W-1:0] rom [0:TMASK];
  always @(posedge clk) tex_q <= rom[tex_addr];

  typedef struct packed {
    logic [FB_AW-1:0] a;
    logic [PIX_W-1:0] d;
  } wr_t;
  wr_t exp_q[$];

  int tests = 0, fails = 0, wr_seen = 0;
  bit sb_en = 1'b1;
  bit disp_m = 1'b0, pend_m = 1'b0;
  logic [15:0] fc_m = '0;

  always @(negedge clk) begin
    if (fb_we) begin
      wr_seen++;
      if (sb_en) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL fb_write: unexpected write addr=%0d data=%0d", fb_addr, fb_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (e.a !== fb_addr || e.d !== fb_wdata) begin
            fails++;
            $display("FAIL fb_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                     fb_addr, fb_wdata, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected writes from screen-space rules: every texel in row-major order, clipped, optionally transparent.
  task automatic model_blit(input int x, input int y, input int base, input int w, input int h,
                            output int fk, output int lk, output int cnt);
    int back, px, py, idx;
    wr_t e;
    back = disp_m ? 0 : 1;
    fk = -1; lk = -1; cnt = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = x + c; py = y + r;
        idx = (base + r * w + c) & TMASK;
        if (px >= 0 && px < FB_W && py >= 0 && py < FB_H) begin
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
          if (rom[idx] == '0) continue;
`endif
          e.a = FB_AW'(back * NPIX + py * FB_W + px);
          e.d = rom[idx];
          exp_q.push_back(e);
          if (fk < 0) fk = r * w + c;
          lk = r * w + c;
          cnt++;
        end
      end
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input bit vs, output int stalls);
    stalls = 0;
    @(negedge clk);
    bus.slave_address = a; bus.slave_writedata = d; bus.slave_write = 1'b1; bus.slave_read = 1'b0;
    #1;
    while (bus.slave_waitrequest && stalls < 5000) begin
      stalls++;
      @(negedge clk); #1;
    end
    if (stalls >= 5000) begin
      tests++; fails++;
      $display("FAIL bus_write_timeout: waitrequest still %0d after %0d cycles", bus.slave_waitrequest, stalls);
    end
    vsync = vs;
    @(posedge clk); #1;
    bus.slave_write = 1'b0; vsync = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, 1'b0, s);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.slave_address = a; bus.slave_read = 1'b1;
    #1;
    v = bus.slave_readdata;
    bus.slave_read = 1'b0;
  endtask

  task automatic check_status(input string nm);
    logic [31:0] v;
    read_reg(3'd6, v);
    check(nm, v, {fc_m, 13'b0, pend_m, disp_m, 1'b0});
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    int n = 0;
    do begin
      read_reg(3'd6, v);
      n++;
    end while (v[0] && n < 5000);
    if (v[0]) begin
      tests++; fails++;
      $display("FAIL wait_idle: busy still %0d after %0d reads", v[0], n);
    end
  endtask

  task automatic pulse_vsync();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
  endtask

  task automatic cfg(input int x, input int y, input int base, input int w, input int h);
    wr(3'd0, 32'(x));
    wr(3'd1, 32'(y));
    wr(3'd2, 32'(base));
    wr(3'd3, 32'((h << 8) | w));
  endtask

  task automatic timed_blit(input int x, input int y, input int base, input int w, input int h,
                            output int cnt);
    int n, fk, lk, w0, first_we, last_we;
    n = w * h;
    cfg(x, y, base, w, h);
    model_blit(x, y, base, w, h, fk, lk, cnt);
    w0 = wr_seen; first_we = -1; last_we = -1;
    wr(3'd5, 32'd0);
    bus.slave_address = 3'd6; bus.slave_read = 1'b1;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (fb_we) begin
        if (first_we < 0) first_we = c;
        last_we = c;
      end
      if (c == 1 && n > 0) check("tex_addr_first", tex_addr, base & TMASK);
      if (c == n && n > 0) check("tex_addr_last", tex_addr, (base + n - 1) & TMASK);
      if (c == n + 1) check("busy_last_cycle", bus.slave_readdata[0], 1);
      if (c == n + 2) check("busy_cleared", bus.slave_readdata[0], 0);
    end
    bus.slave_read = 1'b0;
    check("write_count", wr_seen - w0, cnt);
    if (cnt > 0) begin
      check("first_write_cycle", first_we, fk + 2);
      check("last_write_cycle", last_we, lk + 2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d writes pending", exp_q.size());
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, s, fk, lk, w0;
    logic [31:0] v;

    for (int i = 0; i <= TMASK; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? '0 : PIX_W'($urandom_range(1, 63));
    reset = 1'b1; vsync = 1'b0;
    bus.slave_address = '0; bus.slave_write = 1'b0; bus.slave_writedata = '0; bus.slave_read = 1'b0;
    repeat (3) @(posedge clk);
    read_reg(3'd6, v);
    check("reset_status", v, 0);
    check("reset_fb_we", fb_we, 0);
    check("reset_tex_addr", tex_addr, 0);
    check("reset_display_buf", display_buf, 0);
    @(negedge clk); reset = 1'b0;

    read_reg(3'd3, v);
    check("read_other_addr", v, 0);

    // Nominal 4x2 sprite, all texels in bounds.
    for (int i = 100; i < 108; i++) rom[i] = PIX_W'(i - 90);
    timed_blit(10, 20, 100, 4, 2, cnt);
    check("nominal_count", cnt, 8);

    // Clipped at the left and bottom edges.
    for (int i = 300; i < 316; i++) rom[i] = PIX_W'(i - 280);
    timed_blit(-2, FB_H - 2, 300, 4, 4, cnt);
    check("clip_count", cnt, 4);

    timed_blit(5, 5, 0, 0, 3, cnt);
    timed_blit(5, 5, 0, 3, 0, cnt);

    // Zero texel in a 2x1 sprite.
    rom[200] = '0; rom[201] = 6'd7;
    timed_blit(0, 0, 200, 2, 1, cnt);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    check("transparent_count", cnt, 1);
`else
    check("transparent_count", cnt, 2);
`endif

    for (int i = 0; i < 12; i++)
      timed_blit(int'($urandom_range(0, FB_W + 25)) - 20, int'($urandom_range(0, FB_H + 25)) - 20,
                 int'($urandom_range(0, 15000)), int'($urandom_range(0, 10)),
                 int'($urandom_range(0, 10)), cnt);

    // Swap requested, vsync arrives while busy: deferred.
    wr(3'd7, 32'd1); pend_m = 1'b1;
    check_status("status_swap_pending");
    cfg(0, 0, 500, 8, 8);
    model_blit(0, 0, 500, 8, 8, fk, lk, cnt);
    wr(3'd5, 32'd0);
    pulse_vsync();
    check("display_buf_busy_vsync", display_buf, disp_m);
    wait_idle();
    check_status("status_after_busy_vsync");
    pulse_vsync();
    disp_m = ~disp_m; pend_m = 1'b0; fc_m++;
    check("display_buf_swapped", display_buf, 1);
    check_status("status_after_swap");

    // vsync coincident with command acceptance is also deferred; repeated SWAP is idempotent.
    wr(3'd7, 32'd1); wr(3'd7, 32'd1); pend_m = 1'b1;
    cfg(3, 3, 700, 3, 3);
    model_blit(3, 3, 700, 3, 3, fk, lk, cnt);
    bus_write(3'd5, 32'd0, 1'b1, s);
    wait_idle();
    check("display_buf_accept_vsync", display_buf, disp_m);
    check_status("status_after_accept_vsync");
    pulse_vsync();
    disp_m = ~disp_m; pend_m = 1'b0; fc_m++;
    check_status("status_after_second_swap");
    pulse_vsync();
    check_status("status_vsync_no_pending");

    // Fill, with a blit command stalled behind it.
    cfg(3, 4, 50, 3, 2);
    wr(3'd4, 32'h3F);
    for (int i = 0; i < NPIX; i++) begin
      wr_t e;
      e.a = FB_AW'((disp_m ? 0 : 1) * NPIX + i);
      e.d = 6'h3F;
      exp_q.push_back(e);
    end
    w0 = wr_seen;
    wr(3'd5, 32'd1);
    model_blit(3, 4, 50, 3, 2, fk, lk, cnt);
    bus_write(3'd5, 32'd0, 1'b0, s);
    check("fill_stall_cycles", s, NPIX + 1);
    check("fill_write_count", wr_seen - w0, NPIX);
    wait_idle();
    check("fill_blit_writes", wr_seen - w0, NPIX + cnt);

    // Reset in the middle of a large blit.
    cfg(0, 0, 400, 8, 8);
    sb_en = 1'b0;
    wr(3'd5, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    w0 = wr_seen;
    repeat (10) @(negedge clk);
    check("reset_abort_writes", wr_seen - w0, 0);
    read_reg(3'd6, v);
    check("reset_abort_status", v, 0);
    check("reset_abort_tex_addr", tex_addr, 0);
    check("reset_abort_display_buf", display_buf, 0);
    @(negedge clk); reset = 1'b0;
    exp_q.delete();
    disp_m = 1'b0; pend_m = 1'b0; fc_m = '0;
    sb_en = 1'b1;
    timed_blit(1, 1, 10, 2, 2, cnt);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
